// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bus: ID-stage instruction description and the EX-stage
// flush go in; pipeline enables, the bubble request, the pending-write mask
// and the stall counter come out.
//   master : pipeline side (drives id_* and flush)
//   slave  : scoreboard side (drives pc_write, if_id_write, bubble,
//            pending_mask, stall_count)
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             id_valid;
    logic [4:0]       id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;
    logic             pc_write;
    logic             if_id_write;
    logic             bubble;
    logic [31:0]      pending_mask;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_valid,
               id_rd, id_regwrite, id_memread, flush,
        input  pc_write, if_id_write, bubble, pending_mask, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_valid,
               id_rd, id_regwrite, id_memread, flush,
        output pc_write, if_id_write, bubble, pending_mask, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a 5-stage in-order pipeline. Tracks the EX/MEM/WB
// destination registers in a shadow pipeline and stalls ID on load-use
// hazards (and on WB hazards when the register file lacks write-through).
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   hz      : hazard_scoreboard_if slave modport (ID info, flush in;
//             pc_write, if_id_write, bubble, pending_mask, stall_count out)
//
// state | meaning
// RUN   | normal issue, no stall in progress
// STALL | ID is being held for a hazard cycle
// FLUSH | EX resolved a taken branch/jump; IF and ID were killed
module hazard_scoreboard #(
    parameter bit REGFILE_BYPASS = 1'b1,
    parameter int CNT_W          = 16
) (
    input logic            clk,
    input logic            reset_n,
    hazard_scoreboard_if.slave hz
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } entry_t;

    entry_t           ex_q, mem_q, wb_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_q;
    logic             hazard, stall;
    logic             pc_write, if_id_write, bubble;
    logic [31:0]      mask;

    function automatic logic src_match(input logic valid, input logic uses,
                                       input logic [4:0] rs, input entry_t e);
        return valid && uses && (rs != 5'd0) && (rs == e.rd) && e.valid && e.regwrite;
    endfunction

    logic match_ex, match_wb;

    always_comb begin
        match_ex = src_match(hz.id_valid, hz.id_uses_rs1, hz.id_rs1, ex_q) ||
                   src_match(hz.id_valid, hz.id_uses_rs2, hz.id_rs2, ex_q);
        match_wb = src_match(hz.id_valid, hz.id_uses_rs1, hz.id_rs1, wb_q) ||
                   src_match(hz.id_valid, hz.id_uses_rs2, hz.id_rs2, wb_q);
        // MEM matches and ALU results in EX are covered by forwarding.
        hazard = (match_ex && ex_q.memread) || (!REGFILE_BYPASS && match_wb);
        stall  = hazard && !hz.flush;
    end

    // Outputs are combinational so the stall takes effect in the hazard cycle.
    // Reset forces the idle values even if flush is asserted meanwhile.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        bubble      = hz.flush;
        if (!reset_n) begin
            bubble = 1'b0;
        end else if (stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            bubble      = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (hz.flush)   state_d = FLUSH;
                else if (hazard) state_d = STALL;
            end
            STALL: begin
                if (hz.flush)   state_d = FLUSH;
                else if (hazard) state_d = STALL;
                else             state_d = RUN;
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            if (bubble) begin
                ex_q <= '0;
            end else begin
                ex_q.valid    <= hz.id_valid;
                ex_q.rd       <= hz.id_rd;
                ex_q.regwrite <= hz.id_regwrite;
                ex_q.memread  <= hz.id_memread;
            end
            if (!pc_write && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + 1'b1;
        end
    end

    always_comb begin
        mask = '0;
        if (ex_q.valid  && ex_q.regwrite  && (ex_q.rd  != 5'd0)) mask[ex_q.rd]  = 1'b1;
        if (mem_q.valid && mem_q.regwrite && (mem_q.rd != 5'd0)) mask[mem_q.rd] = 1'b1;
        if (wb_q.valid  && wb_q.regwrite  && (wb_q.rd  != 5'd0)) mask[wb_q.rd]  = 1'b1;
    end

    assign hz.pc_write     = pc_write;
    assign hz.if_id_write  = if_id_write;
    assign hz.bubble       = bubble;
    assign hz.pending_mask = mask;
    assign hz.stall_count  = stall_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    hazard_scoreboard_if #(.CNT_W(16)) hz0 ();
    hazard_scoreboard_if #(.CNT_W(2))  hz1 ();

    hazard_scoreboard #(.REGFILE_BYPASS(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .hz(hz0));
    hazard_scoreboard #(.REGFILE_BYPASS(1'b0), .CNT_W(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .hz(hz1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // valid, rs1, uses_rs1, rs2, uses_rs2, rd, regwrite, memread, flush
    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic fl);
        hz0.id_valid = v;  hz1.id_valid = v;
        hz0.id_rs1 = rs1;  hz1.id_rs1 = rs1;
        hz0.id_uses_rs1 = u1; hz1.id_uses_rs1 = u1;
        hz0.id_rs2 = rs2;  hz1.id_rs2 = rs2;
        hz0.id_uses_rs2 = u2; hz1.id_uses_rs2 = u2;
        hz0.id_rd = rd;    hz1.id_rd = rd;
        hz0.id_regwrite = rw; hz1.id_regwrite = rw;
        hz0.id_memread = mr;  hz1.id_memread = mr;
        hz0.flush = fl;    hz1.flush = fl;
        #2;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        idle();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (hz0.pc_write !== 1'b1) begin n_err++; $display("FAIL rst_pc_write got %b want 1", hz0.pc_write); end
        n_cmp++; if (hz0.if_id_write !== 1'b1) begin n_err++; $display("FAIL rst_if_id_write got %b want 1", hz0.if_id_write); end
        n_cmp++; if (hz0.bubble !== 1'b0) begin n_err++; $display("FAIL rst_bubble got %b want 0", hz0.bubble); end
        n_cmp++; if (hz0.pending_mask !== 32'h0) begin n_err++; $display("FAIL rst_mask got %h want 0", hz0.pending_mask); end
        n_cmp++; if (hz0.stall_count !== 16'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", hz0.stall_count); end
        n_cmp++; if (dut0.state_q !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", dut0.state_q); end
        apply_reset();
    endtask

    task automatic test_load_use();
        apply_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);     // lw x5
        n_cmp++; if (hz0.pc_write !== 1'b1) begin n_err++; $display("FAIL lu_load_pc got %b want 1", hz0.pc_write); end
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);     // add x6,x5
        n_cmp++; if (hz0.pc_write !== 1'b0) begin n_err++; $display("FAIL lu_stall_pc got %b want 0", hz0.pc_write); end
        n_cmp++; if (hz0.if_id_write !== 1'b0) begin n_err++; $display("FAIL lu_stall_ifid got %b want 0", hz0.if_id_write); end
        n_cmp++; if (hz0.bubble !== 1'b1) begin n_err++; $display("FAIL lu_stall_bubble got %b want 1", hz0.bubble); end
        n_cmp++; if (hz0.pending_mask !== 32'h20) begin n_err++; $display("FAIL lu_mask got %h want 20", hz0.pending_mask); end
        tick();
        n_cmp++; if (hz0.pc_write !== 1'b1) begin n_err++; $display("FAIL lu_issue_pc got %b want 1", hz0.pc_write); end
        n_cmp++; if (hz0.bubble !== 1'b0) begin n_err++; $display("FAIL lu_issue_bubble got %b want 0", hz0.bubble); end
        n_cmp++; if (hz0.stall_count !== 16'd1) begin n_err++; $display("FAIL lu_count got %0d want 1", hz0.stall_count); end
        n_cmp++; if (dut0.state_q !== 2'd1) begin n_err++; $display("FAIL lu_state got %0d want 1", dut0.state_q); end
        tick();
        idle();
        n_cmp++; if (hz0.pending_mask !== 32'h60) begin n_err++; $display("FAIL lu_mask_after got %h want 60", hz0.pending_mask); end
        n_cmp++; if (hz0.stall_count !== 16'd1) begin n_err++; $display("FAIL lu_count_after got %0d want 1", hz0.stall_count); end
        n_cmp++; if (dut0.state_q !== 2'd0) begin n_err++; $display("FAIL lu_state_after got %0d want 0", dut0.state_q); end
    endtask

    task automatic test_forward();
        apply_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);     // add x5
        n_cmp++; if (hz0.pending_mask !== 32'h0) begin n_err++; $display("FAIL fw_mask0 got %h want 0", hz0.pending_mask); end
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);     // consumer of x5
        n_cmp++; if (hz0.pc_write !== 1'b1) begin n_err++; $display("FAIL fw_pc got %b want 1", hz0.pc_write); end
        n_cmp++; if (hz0.bubble !== 1'b0) begin n_err++; $display("FAIL fw_bubble got %b want 0", hz0.bubble); end
        for (int c = 1; c <= 3; c++) begin
            n_cmp++; if (hz0.pending_mask !== 32'h20) begin n_err++; $display("FAIL fw_mask_c%0d got %h want 20", c, hz0.pending_mask); end
            tick();
            idle();
        end
        n_cmp++; if (hz0.pending_mask !== 32'h0) begin n_err++; $display("FAIL fw_mask_end got %h want 0", hz0.pending_mask); end
        n_cmp++; if (hz0.stall_count !== 16'd0) begin n_err++; $display("FAIL fw_count got %0d want 0", hz0.stall_count); end
    endtask

    task automatic test_x0();
        apply_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);     // lw x0
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (hz0.pc_write !== 1'b1) begin n_err++; $display("FAIL x0_pc got %b want 1", hz0.pc_write); end
        n_cmp++; if (hz0.bubble !== 1'b0) begin n_err++; $display("FAIL x0_bubble got %b want 0", hz0.bubble); end
        n_cmp++; if (hz0.pending_mask !== 32'h0) begin n_err++; $display("FAIL x0_mask got %h want 0", hz0.pending_mask); end
    endtask

    task automatic test_flush_priority();
        apply_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);     // lw x5
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);     // add x6,x5 + flush
        n_cmp++; if (hz0.pc_write !== 1'b1) begin n_err++; $display("FAIL fl_pc got %b want 1", hz0.pc_write); end
        n_cmp++; if (hz0.if_id_write !== 1'b1) begin n_err++; $display("FAIL fl_ifid got %b want 1", hz0.if_id_write); end
        n_cmp++; if (hz0.bubble !== 1'b1) begin n_err++; $display("FAIL fl_bubble got %b want 1", hz0.bubble); end
        tick();
        idle();
        n_cmp++; if (dut0.state_q !== 2'd2) begin n_err++; $display("FAIL fl_state got %0d want 2", dut0.state_q); end
        n_cmp++; if (hz0.pending_mask !== 32'h20) begin n_err++; $display("FAIL fl_ex_invalid mask got %h want 20", hz0.pending_mask); end
        n_cmp++; if (hz0.stall_count !== 16'd0) begin n_err++; $display("FAIL fl_count got %0d want 0", hz0.stall_count); end
        tick();
        n_cmp++; if (dut0.state_q !== 2'd0) begin n_err++; $display("FAIL fl_state_after got %0d want 0", dut0.state_q); end
    endtask

    task automatic test_wb_bypass();
        apply_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);     // add x7
        tick();
        idle();
        tick();
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);     // reads x7, writer in WB
        n_cmp++; if (hz1.pc_write !== 1'b0) begin n_err++; $display("FAIL wb_nobyp_pc got %b want 0", hz1.pc_write); end
        n_cmp++; if (hz1.bubble !== 1'b1) begin n_err++; $display("FAIL wb_nobyp_bubble got %b want 1", hz1.bubble); end
        n_cmp++; if (hz0.pc_write !== 1'b1) begin n_err++; $display("FAIL wb_byp_pc got %b want 1", hz0.pc_write); end
        n_cmp++; if (hz0.bubble !== 1'b0) begin n_err++; $display("FAIL wb_byp_bubble got %b want 0", hz0.bubble); end
        tick();
        n_cmp++; if (hz1.pc_write !== 1'b1) begin n_err++; $display("FAIL wb_nobyp_release got %b want 1", hz1.pc_write); end
        n_cmp++; if (hz1.stall_count !== 2'd1) begin n_err++; $display("FAIL wb_nobyp_count got %0d want 1", hz1.stall_count); end
        n_cmp++; if (hz0.stall_count !== 16'd0) begin n_err++; $display("FAIL wb_byp_count got %0d want 0", hz0.stall_count); end
        tick();
        idle();
    endtask

    task automatic test_saturate_and_reset();
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
            tick();
            set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
            n_cmp++; if (hz1.pc_write !== 1'b0) begin n_err++; $display("FAIL sat_stall_%0d got %b want 0", i, hz1.pc_write); end
            tick();
            n_cmp++; if (hz1.stall_count !== ((i < 3) ? 2'(i) : 2'd3)) begin n_err++; $display("FAIL sat_count_%0d got %0d want %0d", i, hz1.stall_count, (i < 3) ? i : 3); end
            tick();
        end
        // Reset in the middle of a stall cycle.
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (hz1.pc_write !== 1'b0) begin n_err++; $display("FAIL mid_pre_pc got %b want 0", hz1.pc_write); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (hz1.pc_write !== 1'b1) begin n_err++; $display("FAIL mid_rst_pc got %b want 1", hz1.pc_write); end
        n_cmp++; if (hz1.if_id_write !== 1'b1) begin n_err++; $display("FAIL mid_rst_ifid got %b want 1", hz1.if_id_write); end
        n_cmp++; if (hz1.bubble !== 1'b0) begin n_err++; $display("FAIL mid_rst_bubble got %b want 0", hz1.bubble); end
        n_cmp++; if (hz1.pending_mask !== 32'h0) begin n_err++; $display("FAIL mid_rst_mask got %h want 0", hz1.pending_mask); end
        n_cmp++; if (hz1.stall_count !== 2'd0) begin n_err++; $display("FAIL mid_rst_count got %0d want 0", hz1.stall_count); end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #2;
        n_cmp++; if (dut1.state_q !== 2'd0) begin n_err++; $display("FAIL post_rst_state got %0d want 0", dut1.state_q); end
        n_cmp++; if (hz1.pc_write !== 1'b1) begin n_err++; $display("FAIL post_rst_pc got %b want 1", hz1.pc_write); end
        tick();
        n_cmp++; if (hz1.stall_count !== 2'd0) begin n_err++; $display("FAIL post_rst_count got %0d want 0", hz1.stall_count); end
        idle();
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_forward();
        test_x0();
        test_flush_priority();
        test_wb_bypass();
        test_saturate_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter REGFILE_BYPASS, default 1: 1 means the register file writes through to same-cycle reads; 0 means it does not.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port id_rs1, input, 5 bits: source register 1 of the instruction in ID.
REQ-006 The block SHALL have port id_rs2, input, 5 bits: source register 2 of the instruction in ID.
REQ-007 The block SHALL have ports id_uses_rs1 and id_uses_rs2, input, 1 bit each: the ID instruction reads rs1 / rs2.
REQ-008 The block SHALL have port id_valid, input, 1 bit: ID holds a real instruction.
REQ-009 The block SHALL have port id_rd, input, 5 bits: destination register of the ID instruction.
REQ-010 The block SHALL have port id_regwrite, input, 1 bit: the ID instruction writes rd.
REQ-011 The block SHALL have port id_memread, input, 1 bit: the ID instruction is a load.
REQ-012 The block SHALL have port flush, input, 1 bit: a taken branch or jump resolved in EX; kills IF and ID.
REQ-013 The block SHALL have ports pc_write and if_id_write, output, 1 bit each: enables for the PC and the IF/ID register.
REQ-014 The block SHALL have port bubble, output, 1 bit: zero the ID/EX control signals this cycle.
REQ-015 The block SHALL have port pending_mask, output, 32 bits: bit r set while any in-flight instruction will write register r.
REQ-016 The block SHALL have port stall_count, output, CNT_W bits: number of cycles stalled.

Function
REQ-017 The block SHALL keep a shadow pipeline of three entries, EX, MEM and WB; each entry holds valid, rd, regwrite and memread.
REQ-018 Every cycle the shadow pipeline SHALL advance: WB<=MEM, MEM<=EX.
REQ-019 EX SHALL load {id_valid, id_rd, id_regwrite, id_memread} when neither bubble nor flush is asserted; otherwise EX SHALL load valid=0.
REQ-020 A source match SHALL be: id_valid, id_uses_rsN, id_rsN!=0, and id_rsN equal to the entry rd, with the entry valid and regwrite.
REQ-021 A load-use hazard SHALL exist when a source matches the EX entry and that entry has memread=1.
REQ-022 When REGFILE_BYPASS=0, a source match on the WB entry SHALL also be a hazard.
REQ-023 All other matches SHALL NOT be hazards, because they are covered by the EX/MEM and MEM/WB forwarding paths.
REQ-024 The FSM states SHALL be RUN, STALL and FLUSH.
REQ-025 In RUN, a hazard with flush=0 SHALL move the FSM to STALL; flush=1 SHALL move it to FLUSH.
REQ-026 STALL SHALL be the state entered for the stall cycle; it SHALL return to RUN when the hazard clears, or go to FLUSH if flush=1.
REQ-027 A load-use stall SHALL last exactly 1 cycle; a WB stall (REGFILE_BYPASS=0) SHALL last 1 cycle.
REQ-028 FLUSH SHALL last 1 cycle and then go to RUN.
REQ-029 While a hazard is present and flush=0, the outputs SHALL be combinational: pc_write=0, if_id_write=0, bubble=1.
REQ-030 Otherwise pc_write and if_id_write SHALL be 1, and bubble SHALL equal flush.
REQ-031 flush SHALL have priority over a hazard in the same cycle: no stall, EX loads a bubble.
REQ-032 pending_mask SHALL be the OR of one-hot(rd) over the valid, regwrite, rd!=0 entries; bit 0 SHALL always be 0.
REQ-033 stall_count SHALL increment on each cycle with pc_write=0 and SHALL saturate at all-ones.

Reset
REQ-034 On reset_n=0 the block SHALL asynchronously clear all shadow entries and stall_count, and set the FSM to RUN.
REQ-035 During reset the outputs SHALL be pc_write=1, if_id_write=1, bubble=0 and pending_mask=0.
REQ-036 A reset asserted during STALL or FLUSH SHALL abort that state; the first cycle after release SHALL be RUN with no stall.

Verification
REQ-037 Load x5, then add using rs1=x5 next cycle -> exactly 1 cycle of pc_write=0, bubble=1; stall_count=1; then the add issues.
REQ-038 ALU writing x5, then a consumer of x5 -> no stall (forwarded); pending_mask[5]=1 for 3 cycles.
REQ-039 Load x0, then a consumer of x0 -> no stall; pending_mask=0.
REQ-040 Load-use hazard with flush=1 in the same cycle -> pc_write=1, bubble=1, FSM goes to FLUSH, and the EX entry is invalid next cycle.
REQ-041 REGFILE_BYPASS=0: a writer of x7 in WB and an ID read of x7 -> 1-cycle stall; with REGFILE_BYPASS=1 -> no stall.
REQ-042 Force stall_count to all-ones, then apply a further stall -> the count holds; reset_n low mid-stall -> all outputs at reset values immediately.
